// File: rtl/pulse_train_generator.sv
// Burst pulse generator: emits a programmed number of pulses on pulse_out.
// The high and low widths are programmable in clk cycles and latched when start is accepted.
module pulse_train_generator #(
    parameter int W  = 8,
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  count,
    input  logic [TW-1:0] high_cycles,
    input  logic [TW-1:0] low_cycles,
    input  logic          abort,
    output logic          pulse_out,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  sent
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  count_q, count_d;
    logic [TW-1:0] high_q, high_d;
    logic [TW-1:0] low_q, low_d;
    logic [TW-1:0] phase_q, phase_d;
    logic [W-1:0]  sent_q, sent_d;
    logic          pulse_q, pulse_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [TW-1:0] high_eff;
    logic [TW-1:0] low_eff;

    // A zero-length phase is widened to one cycle so every pulse is visible.
    assign high_eff = (high_cycles == '0) ? TW'(1) : high_cycles;
    assign low_eff  = (low_cycles == '0) ? TW'(1) : low_cycles;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        high_d  = high_q;
        low_d   = low_q;
        phase_d = phase_q;
        sent_d  = sent_q;
        pulse_d = pulse_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                pulse_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    sent_d = '0;
                    if (count != '0) begin
                        count_d = count;
                        high_d  = high_eff;
                        low_d   = low_eff;
                        phase_d = high_eff;
                        busy_d  = 1'b1;
                        pulse_d = 1'b1;
                        state_d = HIGH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (abort) begin
                    state_d = IDLE;
                    pulse_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (phase_q == TW'(1)) begin
                    pulse_d = 1'b0;
                    sent_d  = sent_q + W'(1);
                    phase_d = low_q;
                    state_d = LOW;
                end else begin
                    phase_d = phase_q - TW'(1);
                end
            end
            LOW: begin
                // The last pulse still gets its full low gap before the burst ends.
                if (abort) begin
                    state_d = IDLE;
                    pulse_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (phase_q == TW'(1)) begin
                    if (sent_q == count_q) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        pulse_d = 1'b1;
                        phase_d = high_q;
                        state_d = HIGH;
                    end
                end else begin
                    phase_d = phase_q - TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            high_q  <= '0;
            low_q   <= '0;
            phase_q <= '0;
            sent_q  <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            high_q  <= high_d;
            low_q   <= low_d;
            phase_q <= phase_d;
            sent_q  <= sent_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign pulse_out = pulse_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sent      = sent_q;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed testbench for pulse_train_generator.
// It drives inputs just after each rising edge and samples the outputs 1 ns later.
module tb_pulse_train_generator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  count = '0;
    logic [15:0] high_cycles = '0;
    logic [15:0] low_cycles = '0;
    logic        abort = 1'b0;
    logic        pulse_out;
    logic        busy;
    logic        done;
    logic [7:0]  sent;

    int total = 0;
    int bad = 0;
    int edges = 0;

    pulse_train_generator #(.W(8), .TW(16)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .count(count),
        .high_cycles(high_cycles),
        .low_cycles(low_cycles),
        .abort(abort),
        .pulse_out(pulse_out),
        .busy(busy),
        .done(done),
        .sent(sent)
    );

    always #5 clk = ~clk;

    // Counts rising edges on the pin, like the receiving counter does.
    always @(posedge pulse_out) edges++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input int c, input int h, input int l, input logic a);
        start       = s;
        count       = c[7:0];
        high_cycles = h[15:0];
        low_cycles  = l[15:0];
        abort       = a;
        tick();
    endtask

    // Entered just after the accepting edge. Walks the whole burst and ends in the done cycle.
    task automatic checkBurst(input int n, input int h, input int l, input bit perturb);
        int p;
        int pos;
        p = h + l;
        for (int i = 0; i < n * p; i++) begin
            pos = i % p;
            checkOutput("burst_pulse", pulse_out, (pos < h) ? 1 : 0);
            checkOutput("burst_busy", busy, 1);
            checkOutput("burst_done", done, 0);
            checkOutput("burst_sent", sent, i / p + ((pos >= h) ? 1 : 0));
            start = 1'b0;
            abort = 1'b0;
            if (perturb) begin
                start       = 1'($urandom_range(0, 1));
                count       = 8'($urandom_range(1, 255));
                high_cycles = 16'($urandom_range(0, 20));
                low_cycles  = 16'($urandom_range(0, 20));
            end
            tick();
        end
        checkOutput("end_busy", busy, 0);
        checkOutput("end_done", done, 1);
        checkOutput("end_sent", sent, n);
        checkOutput("end_pulse", pulse_out, 0);
        start = 1'b0;
    endtask

    initial begin
        bit seenDone;

        // Reset state
        tick();
        tick();
        checkOutput("rst_pulse", pulse_out, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_sent", sent, 0);
        rst = 1'b0;

        // Basic burst: 3 pulses, 2 cycles high, 4 cycles low
        applyStimulus(1'b1, 3, 2, 4, 1'b0);
        checkBurst(3, 2, 4, 1'b0);
        tick();
        checkOutput("basic_done_once", done, 0);

        // A zero count finishes at once and clears sent
        applyStimulus(1'b1, 0, 2, 2, 1'b0);
        checkOutput("zero_done", done, 1);
        checkOutput("zero_busy", busy, 0);
        checkOutput("zero_pulse", pulse_out, 0);
        checkOutput("zero_sent", sent, 0);
        applyStimulus(1'b0, 0, 0, 0, 1'b0);
        checkOutput("zero_done_clr", done, 0);
        checkOutput("zero_busy2", busy, 0);

        // Zero high and low widths behave as one cycle each
        applyStimulus(1'b1, 2, 0, 0, 1'b0);
        checkBurst(2, 1, 1, 1'b0);
        tick();

        // Abort in the second high cycle of the third pulse
        applyStimulus(1'b1, 5, 3, 3, 1'b0);
        start = 1'b0;
        for (int i = 0; i < 13; i++) tick();
        checkOutput("abort_pre_pulse", pulse_out, 1);
        checkOutput("abort_pre_sent", sent, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_pulse", pulse_out, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_sent", sent, 2);
        tick();
        checkOutput("abort_idle_pulse", pulse_out, 0);
        checkOutput("abort_no_done", done, 0);

        // When start and abort are both high in IDLE, start wins
        applyStimulus(1'b1, 1, 1, 1, 1'b1);
        checkBurst(1, 1, 1, 1'b0);
        tick();

        // Start, count and widths change during the burst and must be ignored
        applyStimulus(1'b1, 4, 3, 2, 1'b0);
        checkBurst(4, 3, 2, 1'b1);

        // A start in the done cycle begins the next burst immediately
        applyStimulus(1'b1, 2, 1, 2, 1'b0);
        checkOutput("b2b_first_pulse", pulse_out, 1);
        checkOutput("b2b_sent", sent, 0);
        checkBurst(2, 1, 2, 1'b0);
        tick();

        // Reset in the middle of a high phase
        applyStimulus(1'b1, 3, 4, 4, 1'b0);
        start = 1'b0;
        tick();
        checkOutput("mid_pulse_before", pulse_out, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid_rst_pulse", pulse_out, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_done", done, 0);
        checkOutput("mid_rst_sent", sent, 0);
        tick();
        checkOutput("mid_rst_stays", busy, 0);

        // Long burst counted through the rising-edge counter
        edges = 0;
        seenDone = 1'b0;
        applyStimulus(1'b1, 200, 5, 5, 1'b0);
        start = 1'b0;
        for (int i = 0; i < 2100 && !seenDone; i++) begin
            tick();
            if (done) seenDone = 1'b1;
        end
        checkOutput("loop_done_seen", seenDone, 1);
        checkOutput("loop_edges", edges, 200);
        checkOutput("loop_sent", sent, 200);
        checkOutput("loop_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pulse_train_generator.md
# pulse_train_generator

Transmit-side counterpart to the FPGA's pulse-counting input path. It drives a single output pin toward the STM32 with a burst of a programmed number of pulses, each of programmable high and low width in `clk` cycles. The STM32 side counts the rising edges. The block sits in `top` on the PLL clock domain, with `pulse_out` routed to the test pin.

## Interface
Parameters:
- `W`, default 8: width of the pulse count and of `sent`.
- `TW`, default 16: width of the high/low phase length fields.

Ports:
- `clk`, input, 1: PLL system clock. All logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: burst request. Sampled only in IDLE.
- `count`, input, W: number of pulses in the burst. Latched on an accepted `start`.
- `high_cycles`, input, TW: high phase length. Latched on an accepted `start`. A value of 0 is treated as 1.
- `low_cycles`, input, TW: low phase length following each pulse. Latched on an accepted `start`. A value of 0 is treated as 1.
- `abort`, input, 1: terminates a burst in progress.
- `pulse_out`, output, 1: registered pin drive.
- `busy`, output, 1: high while a burst is in progress.
- `done`, output, 1: one-cycle strobe when a burst completes normally.
- `sent`, output, W: number of pulses fully completed (high phase finished) in the current or last burst.

## Operation
States: IDLE, HIGH, LOW.

- **IDLE**
  - `pulse_out`=0, `busy`=0.
  - If `start` is high and `count`≠0:
    - latch `count`, `H`=max(`high_cycles`,1) and `L`=max(`low_cycles`,1);
    - set `sent`<=0, `busy`<=1, `pulse_out`<=1;
    - go to HIGH and load the phase counter with H.
  - If `start` is high and `count`=0: `sent`<=0 and `done`<=1 for one cycle; the state stays IDLE.
- **HIGH**
  - The phase counter decrements each cycle.
  - On the final cycle: `pulse_out`<=0, `sent`<=`sent`+1, go to LOW, and load the phase counter with L.
- **LOW**
  - The phase counter decrements each cycle.
  - On the final cycle, if `sent`==latched `count`: go to IDLE, `busy`<=0, `done`<=1.
  - Otherwise: `pulse_out`<=1 and go to HIGH with the counter loaded with H.
  - Every pulse, including the last, is followed by a full L-cycle low phase. This guarantees the receiver sees a clean gap.

Other rules:
- `abort` high in HIGH or LOW:
  - next edge: IDLE, `pulse_out`<=0, `busy`<=0;
  - `done` is not asserted;
  - `sent` holds the count of completed pulses; a pulse cut off during HIGH is not counted.
- `abort` in IDLE has no effect. If `abort` and `start` are both high in IDLE, `start` is accepted.
- `start` while `busy` is ignored.
- Input changes while `busy` are ignored because the values were latched at `start`.
- Reset values: state=IDLE, `pulse_out`=0, `busy`=0, `done`=0, `sent`=0, counters=0.
- `rst` has priority over all inputs, including mid-burst. At the next edge `pulse_out` is 0 and the burst is discarded.
- `sent` never exceeds `count` and does not wrap. The maximum burst is 2^W−1 pulses.

## Timing
- `start` is sampled at edge k.
- `pulse_out` is high in cycles k+1 … k+H, which is exactly H cycles.
- Pulse period is H+L cycles. The rising edge of pulse n (n from 0) appears after edge k+n·(H+L).
- `sent` increments at edge k+(n+1)·H+n·L.
- `done` and `busy`=0 take effect after edge k+count·(H+L), in the same cycle. `busy` is high for exactly count·(H+L) cycles.
- `start` high during the `done` cycle is accepted. A back-to-back burst then begins its pulse one cycle after `done`.
- `pulse_out` is a registered flop output with no combinational path from any input.

## Test plan
- **Basic burst**: reset; `count`=3, `high_cycles`=2, `low_cycles`=4, pulse `start`.
  - Required: `pulse_out` pattern 110000 repeated 3 times.
  - `busy` high for 18 cycles; `done` pulses once in cycle 19; `sent`=3.
- **Zero handling**: `count`=0 with `start` → `done` for one cycle, `busy` never rises, `pulse_out` stays 0. Then `high_cycles`=0, `low_cycles`=0, `count`=2 → pattern 1010 and `sent`=2.
- **Abort**: `count`=5, H=3, L=3; assert `abort` in the second cycle of pulse 3's high phase.
  - Required: `pulse_out` 0 at the next edge, `busy` 0, no `done`, `sent`=2.
- **Ignored inputs**: during a `count`=4 burst, toggle `start` and change `count`/`high_cycles`.
  - Required: exactly 4 pulses with the original widths.
- **Back-to-back bursts**: re-assert `start` during the `done` cycle.
  - Required: the second burst's first high cycle directly follows the `done` cycle, and `sent` restarts at 0.
- **Reset mid-burst and loopback**:
  - Apply `rst` mid-HIGH: all outputs return to reset values next cycle.
  - Loop `pulse_out` into the existing posedge counter with `count`=200, H=L=5: the counter advances by exactly 200.
